pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the RISC-V core. It carries a data bundle and a control bundle with a valid/ready handshake instead of a raw stall vector. A flush inserts a bubble: valid and control are cleared, so the stage can never issue a stray register write or memory write. It sits between any two pipeline stages; every stage boundary instantiates one.

---
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an idle-cycle counter.
// Define PIPE_SKID_EN to add a second (skid) entry and make in_ready a registered output.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       bubble_cnt
);

  logic              in_xfer;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  assign in_xfer  = in_valid && in_ready;
  assign out_data = data_q;
  assign out_ctrl = ctrl_q;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Only flush/reset gate the registered ready; out_ready never reaches in_ready.
  assign in_ready  = in_ready_q && !flush && rst_n;
  assign out_valid = (state_q != ST_EMPTY);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      ctrl_d      = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            data_d  = in_data;
            ctrl_d  = in_ctrl;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (in_xfer) begin
              data_d = in_data;
              ctrl_d = in_ctrl;
            end else begin
              ctrl_d  = '0;
              state_d = ST_EMPTY;
            end
          end else if (in_xfer) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            data_d      = skid_data_q;
            ctrl_d      = skid_ctrl_q;
            skid_ctrl_d = '0;
            state_d     = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          ctrl_d      = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_SKID);
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end
`else
  logic valid_q, valid_d;
  logic out_xfer;

  assign in_ready  = !flush && rst_n && (!valid_q || out_ready);
  assign out_valid = valid_q;
  assign out_xfer  = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (in_xfer) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end else if (out_xfer) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end
`endif

  logic [15:0] bubble_cnt_q;

  assign bubble_cnt = bubble_cnt_q;

  // Counts downstream-ready cycles with nothing to give; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (!flush && out_ready && !out_valid && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: reset, bubble counter, streaming, stall, flush.
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [15:0] out_ctrl;
  logic [15:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [95:0] d, input logic [15:0] c, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 96'h1234, 16'hFFFF, 1'b1, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    step();
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, 16'h0);
    check("rst_out_data", out_data, 96'h0);
    check("rst_bubble", bubble_cnt, 16'h0);

    // Bubble counter from reset
    rst_n = 1'b1;
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("bub_5", bubble_cnt, 16'd5);
    drive(1'b0, 96'h0, 16'h0, 1'b0, 1'b0);
    step();
    check("bub_notready_hold", bubble_cnt, 16'd5);
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b1);
    check("flush_in_ready", in_ready, 1'b0);
    step();
    check("bub_flush_hold", bubble_cnt, 16'd5);
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 16'hFFFE - 5; i++) @(posedge clk);
    #1;
    check("bub_fffe", bubble_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) step();
    check("bub_sat", bubble_cnt, 16'hFFFF);

    rst_n = 1'b0;
    step();
    check("rst2_bubble", bubble_cnt, 16'h0);
    rst_n = 1'b1;

    // Streaming 1..8 back-to-back
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 96'(i), 16'(16'h100 | i), 1'b1, 1'b0);
      check($sformatf("stream_in_ready_%0d", i), in_ready, 1'b1);
      step();
      check($sformatf("stream_valid_%0d", i), out_valid, 1'b1);
      check($sformatf("stream_data_%0d", i), out_data, 96'(i));
      check($sformatf("stream_ctrl_%0d", i), out_ctrl, 16'(16'h100 | i));
    end
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b0);
    step();
    check("drain_valid", out_valid, 1'b0);
    check("drain_ctrl", out_ctrl, 16'h0);
    check("drain_data_held", out_data, 96'h8);

    // Stall hold
    drive(1'b1, 96'h55, 16'h00A5, 1'b1, 1'b0);
    step();
    check("stall_load", out_data, 96'h55);
    drive(1'b1, 96'h66, 16'h00B6, 1'b0, 1'b0);
`ifdef PIPE_SKID_EN
    check("stall_skid_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b1;
    #1;
    check("stall_skid_full", in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("stall_hold_data_%0d", i), out_data, 96'h55);
      check($sformatf("stall_hold_ctrl_%0d", i), out_ctrl, 16'h00A5);
    end
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b0);
    step();
    check("stall_release_data", out_data, 96'h66);
    check("stall_release_ctrl", out_ctrl, 16'h00B6);
    step();
    check("stall_empty", out_valid, 1'b0);

    // Flush while in SKID
    drive(1'b1, 96'h11, 16'h0011, 1'b1, 1'b0);
    step();
    drive(1'b1, 96'h22, 16'h0022, 1'b0, 1'b0);
    step();
    drive(1'b0, 96'h0, 16'h0, 1'b0, 1'b1);
    step();
    flush = 1'b0;
    #1;
    check("skflush_valid", out_valid, 1'b0);
    check("skflush_ctrl", out_ctrl, 16'h0);
    check("skflush_in_ready", in_ready, 1'b1);
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b0);
    step();
    check("skflush_no_skid", out_valid, 1'b0);
`else
    check("stall_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold_data_%0d", i), out_data, 96'h55);
      check($sformatf("stall_hold_ctrl_%0d", i), out_ctrl, 16'h00A5);
      check($sformatf("stall_hold_valid_%0d", i), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1'b1);
    step();
    check("stall_replace_data", out_data, 96'h66);
    check("stall_replace_ctrl", out_ctrl, 16'h00B6);
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b0);
    step();
    check("stall_empty", out_valid, 1'b0);
`endif

    // Flush with simultaneous input while holding a live entry
    drive(1'b1, 96'h77, 16'h0077, 1'b0, 1'b0);
    step();
    check("pre_flush_valid", out_valid, 1'b1);
    drive(1'b1, 96'hAA, 16'h01FF, 1'b1, 1'b1);
    check("flushin_in_ready", in_ready, 1'b0);
    step();
    check("flushin_valid", out_valid, 1'b0);
    check("flushin_ctrl", out_ctrl, 16'h0);
    check("flushin_data_held", out_data, 96'h77);
    drive(1'b0, 96'h0, 16'h0, 1'b1, 1'b0);
    check("post_flush_in_ready", in_ready, 1'b1);
    step();
    check("flushin_never_out", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
